alu_dispatch: RTL and testbench

- Initiator side of the ALU interface: accepts decoded ALU instructions over a valid/ready handshake.
- Reads operands from an internal register file and drives the ALU's enable/opcode/operand/dest/carry-in inputs.
- Captures the ALU's result, dest and flags, then writes the result back into the register file and a flags register.
- Sits between the instruction decoder and the ALU; one instruction in flight at a time.

---
 rtl/alu_dispatch.sv | 103 ++++++++++
 tb/tb_alu_dispatch.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_dispatch.sv
// alu_dispatch: issues decoded instructions to an external ALU and writes its results back
module alu_dispatch #(
  parameter int WIDTH = 32,
  parameter int OPCODE = 4,
  parameter int REGS_CODING = 3,
  parameter int FLAGS = 4,
  parameter logic [OPCODE-1:0] CMP_OPCODE = 4'b1100
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [OPCODE-1:0]      in_opcode,
  input  logic [REGS_CODING-1:0] in_dest,
  input  logic [REGS_CODING-1:0] in_src1,
  input  logic [REGS_CODING-1:0] in_src2,
  input  logic                   in_imm_en,
  input  logic [WIDTH-1:0]       in_imm,
  output logic                   alu_en,
  output logic [OPCODE-1:0]      alu_opcode,
  output logic [WIDTH-1:0]       alu_op1,
  output logic [WIDTH-1:0]       alu_op2,
  output logic                   alu_cin,
  output logic [REGS_CODING-1:0] alu_dest,
  input  logic [WIDTH-1:0]       alu_result,
  input  logic [FLAGS-1:0]       alu_flags,
  input  logic [REGS_CODING-1:0] alu_dest_out,
  output logic [FLAGS-1:0]       flags_out,
  input  logic [REGS_CODING-1:0] dbg_addr,
  output logic [WIDTH-1:0]       dbg_data,
  output logic [15:0]            retired
);
  localparam int NREGS = 2 ** REGS_CODING;
  typedef enum logic [1:0] {IDLE, ISSUE, WB} state_t;
  state_t                 state_q, state_d;
  logic [WIDTH-1:0]       regs_q [NREGS];
  logic [WIDTH-1:0]       regs_d [NREGS];
  logic [OPCODE-1:0]      opcode_q, opcode_d;
  logic [WIDTH-1:0]       op1_q, op1_d, op2_q, op2_d;
  logic [REGS_CODING-1:0] dest_q, dest_d;
  logic [FLAGS-1:0]       flags_q, flags_d;
  logic [15:0]            retired_q, retired_d;
  assign in_ready   = (state_q == IDLE) && !rst;
  assign alu_en     = state_q == ISSUE;
  assign alu_opcode = opcode_q;
  assign alu_op1    = op1_q;
  assign alu_op2    = op2_q;
  assign alu_dest   = dest_q;
  assign alu_cin    = flags_q[0];
  assign flags_out  = flags_q;
  assign retired    = retired_q;
  assign dbg_data   = regs_q[dbg_addr];
  // sequencing: capture operands on accept, hold through ISSUE, commit ALU outputs at end of WB
  always_comb begin
    state_d   = state_q;
    regs_d    = regs_q;
    opcode_d  = opcode_q;
    op1_d     = op1_q;
    op2_d     = op2_q;
    dest_d    = dest_q;
    flags_d   = flags_q;
    retired_d = retired_q;
    case (state_q)
      IDLE: if (in_valid) begin
        opcode_d = in_opcode;
        dest_d   = in_dest;
        op1_d    = regs_q[in_src1];
        op2_d    = in_imm_en ? in_imm : regs_q[in_src2];
        state_d  = ISSUE;
      end
      ISSUE: state_d = WB;
      WB: begin
        flags_d   = alu_flags;
        if (opcode_q != CMP_OPCODE) regs_d[alu_dest_out] = alu_result;
        retired_d = retired_q + 16'd1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  // state registers; reset drops any in-flight instruction
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      regs_q    <= '{default: '0};
      opcode_q  <= '0;
      op1_q     <= '0;
      op2_q     <= '0;
      dest_q    <= '0;
      flags_q   <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      regs_q    <= regs_d;
      opcode_q  <= opcode_d;
      op1_q     <= op1_d;
      op2_q     <= op2_d;
      dest_q    <= dest_d;
      flags_q   <= flags_d;
      retired_q <= retired_d;
    end
  end
endmodule

// File: tb/tb_alu_dispatch.sv
// tb_alu_dispatch: random and directed checks of alu_dispatch against a sequential ISA model
`timescale 1ns/1ps
module tb_alu_dispatch;
  localparam logic [3:0] ADD = 4'd0, ADC = 4'd1, SUB = 4'd2, AND_ = 4'd4, XOR_ = 4'd6, CMP = 4'd12;
  typedef struct {logic [3:0] op; logic [2:0] d; logic [2:0] s1; logic [2:0] s2; logic ie; logic [31:0] imm;} instr_t;
  logic clk = 0, rst = 1, in_valid = 0, in_imm_en = 0;
  logic in_ready, alu_en, alu_cin;
  logic [3:0] in_opcode = 0, alu_opcode, alu_flags = 0, flags_out;
  logic [2:0] in_dest = 0, in_src1 = 0, in_src2 = 0, alu_dest, alu_dest_out = 0, dbg_addr = 0;
  logic [31:0] in_imm = 0, alu_op1, alu_op2, alu_result = 0, dbg_data;
  logic [15:0] retired;
  logic [31:0] mreg [8];
  logic [3:0] mflags;
  int mret;
  int n_vec = 0, n_err = 0, cyc = 0;
  int acc_q[$];

  alu_dispatch dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode),
    .in_dest(in_dest), .in_src1(in_src1), .in_src2(in_src2), .in_imm_en(in_imm_en), .in_imm(in_imm),
    .alu_en(alu_en), .alu_opcode(alu_opcode), .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_cin(alu_cin),
    .alu_dest(alu_dest), .alu_result(alu_result), .alu_flags(alu_flags), .alu_dest_out(alu_dest_out),
    .flags_out(flags_out), .dbg_addr(dbg_addr), .dbg_data(dbg_data), .retired(retired)
  );

  always #50 clk = ~clk;

  // ALU semantics: flags {zero, overflow, sign, carry}, result in low 32 bits
  function automatic logic [35:0] alu_fn(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic c);
    logic [32:0] s;
    logic ov;
    ov = 1'b0;
    if (op == ADD || op == ADC) begin
      s = {1'b0, a} + {1'b0, b} + {32'd0, op == ADC && c};
      ov = (a[31] == b[31]) && (s[31] != a[31]);
    end else if (op == SUB || op == CMP) begin
      s = {1'b0, a} - {1'b0, b};
      ov = (a[31] != b[31]) && (s[31] != a[31]);
    end else if (op == AND_) s = {1'b0, a & b};
    else if (op == XOR_) s = {1'b0, a ^ b};
    else s = {1'b0, a | b};
    return {s[31:0] == 32'd0, ov, s[31], s[32], s[31:0]};
  endfunction

  // external ALU: samples on the falling edge while enabled, holds otherwise
  always @(negedge clk) if (alu_en) begin
    {alu_flags, alu_result} <= alu_fn(alu_opcode, alu_op1, alu_op2, alu_cin);
    alu_dest_out <= alu_dest;
  end

  always @(posedge clk) begin
    if (in_valid && in_ready) acc_q.push_back(cyc);
    cyc++;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic apply(input instr_t x);
    logic [35:0] r;
    r = alu_fn(x.op, mreg[x.s1], x.ie ? x.imm : mreg[x.s2], mflags[0]);
    if (x.op != CMP) mreg[x.d] = r[31:0];
    mflags = r[35:32];
    mret++;
  endtask

  task automatic drive(input instr_t x);
    in_opcode = x.op; in_dest = x.d; in_src1 = x.s1; in_src2 = x.s2; in_imm_en = x.ie; in_imm = x.imm;
  endtask

  task automatic sweep();
    for (int i = 0; i < 8; i++) begin
      dbg_addr = 3'(i);
      #1;
      check($sformatf("reg%0d", i), dbg_data, mreg[i]);
    end
  endtask

  task automatic dbg_check(input string tag, input logic [2:0] idx, input logic [31:0] exp);
    dbg_addr = idx;
    #1;
    check(tag, dbg_data, exp);
  endtask

  task automatic send(input instr_t x);
    logic [31:0] a, b;
    for (int k = 0; k < 8 && !in_ready; k++) begin @(posedge clk); #1; end
    check("ready_idle", 32'(in_ready), 32'd1);
    drive(x);
    in_valid = 1;
    dbg_addr = x.d;
    a = mreg[x.s1];
    b = x.ie ? x.imm : mreg[x.s2];
    @(posedge clk); #1;
    in_valid = 0;
    check("issue_en", 32'(alu_en), 32'd1);
    check("issue_ready", 32'(in_ready), 32'd0);
    check("issue_op1", alu_op1, a);
    check("issue_op2", alu_op2, b);
    check("issue_opc", 32'(alu_opcode), 32'(x.op));
    check("issue_dest", 32'(alu_dest), 32'(x.d));
    check("issue_cin", 32'(alu_cin), 32'(mflags[0]));
    @(posedge clk); #1;
    check("wb_en", 32'(alu_en), 32'd0);
    check("wb_ready", 32'(in_ready), 32'd0);
    check("wb_dbg_old", dbg_data, mreg[x.d]);
    apply(x);
    @(posedge clk); #1;
    check("done_ready", 32'(in_ready), 32'd1);
    check("done_flags", 32'(flags_out), 32'(mflags));
    check("done_retired", 32'(retired), 32'(16'(mret)));
    check("done_dbg_new", dbg_data, mreg[x.d]);
  endtask

  function automatic instr_t rand_instr();
    logic [3:0] ops [6];
    instr_t x;
    ops = '{ADD, ADC, SUB, AND_, XOR_, CMP};
    x.op = ops[$urandom_range(0, 5)];
    x.d = 3'($urandom_range(0, 7));
    x.s1 = 3'($urandom_range(0, 7));
    x.s2 = 3'($urandom_range(0, 7));
    x.ie = 1'($urandom_range(0, 1));
    x.imm = $urandom;
    return x;
  endfunction

  initial begin
    instr_t stream [4];
    int base, ready_seen, iters, idx, prev;
    for (int i = 0; i < 8; i++) mreg[i] = '0;
    mflags = '0;
    mret = 0;
    @(posedge clk); #1;
    check("rst_ready", 32'(in_ready), 32'd0);
    check("rst_en", 32'(alu_en), 32'd0);
    @(posedge clk); #1;
    check("rst_ready2", 32'(in_ready), 32'd0);
    check("rst_flags", 32'(flags_out), 32'd0);
    check("rst_retired", 32'(retired), 32'd0);
    check("rst_op1", alu_op1, 32'd0);
    rst = 0;
    #1;
    check("post_rst_ready", 32'(in_ready), 32'd1);
    sweep();
    send('{ADD, 3'd1, 3'd0, 3'd0, 1'b1, 32'd5});
    send('{ADD, 3'd2, 3'd1, 3'd0, 1'b1, 32'd7});
    check("accept_spacing", 32'(acc_q[acc_q.size()-1] - acc_q[acc_q.size()-2]), 32'd3);
    dbg_check("imm_r1", 3'd1, 32'd5);
    dbg_check("imm_r2", 3'd2, 32'd12);
    check("imm_retired", 32'(retired), 32'd2);
    send('{ADD, 3'd3, 3'd0, 3'd0, 1'b1, 32'hFFFF_FFFF});
    send('{ADD, 3'd4, 3'd3, 3'd0, 1'b1, 32'd1});
    check("carry_flag", 32'(flags_out[0]), 32'd1);
    send('{ADC, 3'd5, 3'd0, 3'd0, 1'b1, 32'd0});
    dbg_check("adc_r5", 3'd5, 32'd1);
    send('{CMP, 3'd1, 3'd1, 3'd1, 1'b0, 32'd0});
    check("cmp_zero", 32'(flags_out[3]), 32'd1);
    check("cmp_retired", 32'(retired), 32'd6);
    sweep();
    for (int n = 0; n < 16; n++) send(rand_instr());
    sweep();
    for (int i = 0; i < 4; i++) stream[i] = rand_instr();
    base = acc_q.size();
    ready_seen = 0;
    iters = 0;
    idx = 0;
    prev = base;
    drive(stream[0]);
    in_valid = 1;
    while (idx < 4 && iters < 40) begin
      ready_seen += int'(in_ready);
      @(posedge clk); #1;
      iters++;
      if (acc_q.size() != prev) begin
        apply(stream[idx]);
        idx++;
        prev = acc_q.size();
        if (idx < 4) drive(stream[idx]);
      end
    end
    in_valid = 0;
    check("stream_accepts", 32'(acc_q.size() - base), 32'd4);
    check("stream_ready_pulses", 32'(ready_seen), 32'd4);
    check("stream_cycles", 32'(iters), 32'd10);
    for (int j = 1; j < 4 && base + j < acc_q.size(); j++)
      check($sformatf("stream_spacing%0d", j), 32'(acc_q[base+j] - acc_q[base+j-1]), 32'd3);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("stream_flags", 32'(flags_out), 32'(mflags));
    check("stream_retired", 32'(retired), 32'(16'(mret)));
    sweep();
    for (int k = 0; k < 8 && !in_ready; k++) begin @(posedge clk); #1; end
    drive('{SUB, 3'd6, 3'd0, 3'd0, 1'b1, 32'd9});
    in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0;
    check("midop_issue", 32'(alu_en), 32'd1);
    rst = 1;
    #1;
    check("midop_rst_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    check("midop_en", 32'(alu_en), 32'd0);
    check("midop_op2", alu_op2, 32'd0);
    check("midop_opc", 32'(alu_opcode), 32'd0);
    check("midop_dest", 32'(alu_dest), 32'd0);
    check("midop_flags", 32'(flags_out), 32'd0);
    rst = 0;
    for (int i = 0; i < 8; i++) mreg[i] = '0;
    mflags = '0;
    mret = 0;
    @(posedge clk); #1;
    check("midop_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    check("midop_idle_en", 32'(alu_en), 32'd0);
    check("midop_retired", 32'(retired), 32'd0);
    dbg_check("midop_r6", 3'd6, 32'd0);
    sweep();
    send('{ADD, 3'd6, 3'd0, 3'd0, 1'b1, 32'd9});
    dbg_check("post_midop_r6", 3'd6, 32'd9);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
